// File: rtl/if_fetch_pkg.sv
// Shared types and fetch-state encodings for the instruction-fetch stage.
package if_fetch_pkg;

    typedef logic [31:0] InstructionAddressBus;
    typedef logic [31:0] InstructionBus;
    typedef logic [7:0]  ByteBus;

    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_BUSY = 2'd1;
    localparam logic [1:0] FETCH_HOLD = 2'd2;

endpackage

// File: rtl/if_byte_assembler.sv
// Collects four little-endian bytes into one instruction word, lane 0 first.
module if_byte_assembler
    import if_fetch_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          capture,
    input  ByteBus        din,
    output logic          last,
    output InstructionBus word,
    output InstructionBus word_next
);

    logic [2:0] recv_cnt;

    // word_next already contains the byte arriving this cycle, so the final byte
    // can be presented on the same edge it is captured.
    always_comb begin
        word_next = word;
        if (capture) begin
            word_next[{recv_cnt[1:0], 3'b000} +: 8] = din;
        end
    end

    assign last = capture && (recv_cnt == 3'd3);

    always_ff @(posedge clock) begin
        if (!reset) begin
            recv_cnt <= 3'd0;
            word     <= '0;
        end else if (clear) begin
            recv_cnt <= 3'd0;
            word     <= '0;
        end else if (capture) begin
            recv_cnt <= recv_cnt + 3'd1;
            word     <= word_next;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: four byte reads per instruction over a shared byte port,
// result handed to IF/ID with a valid/stall handshake.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INST_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  ce_in,
    input  logic                  flush,
    input  logic                  id_stall,
    input  logic                  mem_grant,
    input  logic [7:0]            mem_din,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  stall_req,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [INST_WIDTH-1:0] if_inst
);

    generate
        if (INST_WIDTH != 32 || MEM_LATENCY != 1) begin : g_param_check
            $error("if_fetch supports only INST_WIDTH=32 and MEM_LATENCY=1");
        end
    endgenerate

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [2:0]            issue_cnt_q, issue_cnt_d;
    logic                  pending_q, pending_d;
    logic                  if_valid_q, if_valid_d;
    logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [INST_WIDTH-1:0] if_inst_q, if_inst_d;

    logic          issuing, start, capture, asm_clear, last;
    InstructionBus word, word_next;

    assign issuing   = (state_q == FETCH_BUSY) && !issue_cnt_q[2];
    assign start     = (state_q == FETCH_IDLE) && ce_in && !flush;
    // A pending byte is only taken while still fetching; flush or reset drop it.
    assign capture   = (state_q == FETCH_BUSY) && pending_q && !flush;
    assign asm_clear = flush || start;

    assign mem_req   = issuing;
    assign mem_addr  = issuing ? fetch_pc_q + ADDR_WIDTH'(issue_cnt_q) : '0;
    assign stall_req = (state_q != FETCH_IDLE);
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;

    if_byte_assembler u_asm (
        .clock     (clock),
        .reset     (reset),
        .clear     (asm_clear),
        .capture   (capture),
        .din       (mem_din),
        .last      (last),
        .word      (word),
        .word_next (word_next)
    );

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issue_cnt_d = issue_cnt_q;
        pending_d   = 1'b0;
        if_valid_d  = if_valid_q && id_stall;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;
        if (flush) begin
            state_d     = FETCH_IDLE;
            issue_cnt_d = 3'd0;
            if_valid_d  = 1'b0;
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    if (ce_in) begin
                        state_d     = FETCH_BUSY;
                        fetch_pc_d  = pc_in;
                        issue_cnt_d = 3'd0;
                    end
                end
                FETCH_BUSY: begin
                    if (issuing && mem_grant) begin
                        issue_cnt_d = issue_cnt_q + 3'd1;
                        pending_d   = 1'b1;
                    end
                    if (last) begin
                        if (id_stall) begin
                            state_d = FETCH_HOLD;
                        end else begin
                            state_d    = FETCH_IDLE;
                            if_valid_d = 1'b1;
                            if_pc_d    = fetch_pc_q;
                            if_inst_d  = word_next;
                        end
                    end
                end
                FETCH_HOLD: begin
                    if (!id_stall) begin
                        state_d    = FETCH_IDLE;
                        if_valid_d = 1'b1;
                        if_pc_d    = fetch_pc_q;
                        if_inst_d  = word;
                    end
                end
                default: state_d = FETCH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= FETCH_IDLE;
            fetch_pc_q  <= '0;
            issue_cnt_q <= 3'd0;
            pending_q   <= 1'b0;
            if_valid_q  <= 1'b0;
            if_pc_q     <= '0;
            if_inst_q   <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issue_cnt_q <= issue_cnt_d;
            pending_q   <= pending_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a one-cycle-latency byte memory model.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset, ce_in, flush, id_stall, mem_grant;
    InstructionAddressBus pc_in;
    logic [7:0]           mem_din = 8'h00;
    logic                 mem_req, stall_req, if_valid;
    InstructionAddressBus mem_addr, if_pc;
    InstructionBus        if_inst;

    int unsigned total = 0;
    int unsigned bad   = 0;
    InstructionAddressBus issued_q[$];

    if_fetch dut (
        .clock     (clock),
        .reset     (reset),
        .pc_in     (pc_in),
        .ce_in     (ce_in),
        .flush     (flush),
        .id_stall  (id_stall),
        .mem_grant (mem_grant),
        .mem_din   (mem_din),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .stall_req (stall_req),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_inst   (if_inst)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] mem_byte(input InstructionAddressBus a);
        case (a)
            32'h0000_1000: mem_byte = 8'h13;
            32'h0000_1001: mem_byte = 8'h05;
            32'h0000_1002: mem_byte = 8'h10;
            32'h0000_1003: mem_byte = 8'h00;
            32'h0000_2000: mem_byte = 8'h11;
            32'h0000_2001: mem_byte = 8'h22;
            32'h0000_2002: mem_byte = 8'h33;
            32'h0000_2003: mem_byte = 8'h44;
            32'h0000_3000: mem_byte = 8'h93;
            32'h0000_3001: mem_byte = 8'h00;
            32'h0000_3002: mem_byte = 8'h50;
            32'h0000_3003: mem_byte = 8'h00;
            32'hFFFF_FFFE: mem_byte = 8'hEF;
            32'hFFFF_FFFF: mem_byte = 8'hBE;
            32'h0000_0000: mem_byte = 8'hAD;
            32'h0000_0001: mem_byte = 8'hDE;
            default:       mem_byte = 8'hAA;
        endcase
    endfunction

    // Memory answers every granted request one cycle later; genuine issues are logged.
    always @(posedge clock) begin
        if (mem_req && mem_grant) begin
            mem_din <= mem_byte(mem_addr);
            if (reset && !flush) issued_q.push_back(mem_addr);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; ce_in = 1'b0; flush = 1'b0; id_stall = 1'b0; mem_grant = 1'b1;
        pc_in = 32'h0;
        tick();
        tick();
        total++;
        if ({mem_req, mem_addr, stall_req, if_valid, if_pc, if_inst} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: req=%b addr=%h stall=%b valid=%b pc=%h inst=%h want all 0",
                     mem_req, mem_addr, stall_req, if_valid, if_pc, if_inst);
        end
        reset = 1'b1;
        // Mid-fetch reset at 0x4000: bytes returning after it must be ignored.
        pc_in = 32'h0000_4000; ce_in = 1'b1;
        tick();
        ce_in = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        total++;
        if ({mem_req, mem_addr, stall_req, if_valid, if_pc, if_inst} !== '0) begin
            bad++;
            $display("FAIL reset_midfetch: req=%b addr=%h stall=%b valid=%b inst=%h want all 0",
                     mem_req, mem_addr, stall_req, if_valid, if_inst);
        end
        tick();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if ({mem_req, stall_req, if_valid, if_inst} !== '0) begin
                bad++;
                $display("FAIL reset_after c=%0d: req=%b stall=%b valid=%b inst=%h want idle zeros",
                         c, mem_req, stall_req, if_valid, if_inst);
            end
        end
    endtask

    task automatic test_basic();
        issued_q.delete();
        pc_in = 32'h0000_1000; ce_in = 1'b1;
        tick();
        ce_in = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            total++;
            if (stall_req !== 1'b1 || if_valid !== 1'b0) begin
                bad++;
                $display("FAIL basic_stall c=%0d: stall=%b valid=%b want 1/0", c, stall_req, if_valid);
            end
            total++;
            if (c <= 4 && (mem_req !== 1'b1 || mem_addr !== 32'h0000_1000 + c - 1)) begin
                bad++;
                $display("FAIL basic_addr c=%0d: req=%b addr=%h want 1/%h",
                         c, mem_req, mem_addr, 32'h0000_1000 + c - 1);
            end else if (c == 5 && mem_req !== 1'b0) begin
                bad++;
                $display("FAIL basic_noreq c=5: req=%b want 0", mem_req);
            end
            tick();
        end
        total++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0000_1000 || if_inst !== 32'h0010_0513
            || stall_req !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: valid=%b pc=%h inst=%h stall=%b want 1/00001000/00100513/0",
                     if_valid, if_pc, if_inst, stall_req);
        end
        tick();
        total++;
        if (if_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_pulse: valid=%b want 0", if_valid);
        end
    endtask

    task automatic test_bubbles();
        int vcyc;
        vcyc = 0;
        issued_q.delete();
        pc_in = 32'h0000_1000; ce_in = 1'b1;
        tick();
        ce_in = 1'b0;
        for (int c = 1; c <= 20 && vcyc == 0; c++) begin
            if (if_valid === 1'b1) vcyc = c;
            mem_grant = !(c == 2 || c == 3);
            if (vcyc == 0) tick();
        end
        mem_grant = 1'b1;
        total++;
        if (vcyc != 8 || if_inst !== 32'h0010_0513 || if_pc !== 32'h0000_1000) begin
            bad++;
            $display("FAIL bubbles_result: valid_cycle=%0d inst=%h pc=%h want 8/00100513/00001000",
                     vcyc, if_inst, if_pc);
        end
        total++;
        if (issued_q.size() != 4) begin
            bad++;
            $display("FAIL bubbles_count: issued=%0d want 4", issued_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (issued_q[i] !== 32'h0000_1000 + i) begin
                    bad++;
                    $display("FAIL bubbles_order i=%0d: addr=%h want %h",
                             i, issued_q[i], 32'h0000_1000 + i);
                end
            end
        end
        tick();
    endtask

    task automatic test_hold();
        issued_q.delete();
        pc_in = 32'h0000_2000; ce_in = 1'b1;
        tick();
        ce_in = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            id_stall = (c >= 4 && c <= 9);
            if (c >= 6) begin
                total++;
                if (stall_req !== 1'b1 || mem_req !== 1'b0 || if_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL hold_state c=%0d: stall=%b req=%b valid=%b want 1/0/0",
                             c, stall_req, mem_req, if_valid);
                end
            end
            tick();
        end
        total++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0000_2000 || if_inst !== 32'h4433_2211
            || issued_q.size() != 4) begin
            bad++;
            $display("FAIL hold_result: valid=%b pc=%h inst=%h issued=%0d want 1/00002000/44332211/4",
                     if_valid, if_pc, if_inst, issued_q.size());
        end
        id_stall = 1'b1;
        tick();
        total++;
        if (if_valid !== 1'b1 || if_inst !== 32'h4433_2211) begin
            bad++;
            $display("FAIL hold_keep: valid=%b inst=%h want 1/44332211", if_valid, if_inst);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0; id_stall = 1'b0;
        total++;
        if (if_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_over_stall: valid=%b want 0", if_valid);
        end
    endtask

    task automatic test_flush();
        int nvalid;
        nvalid = 0;
        issued_q.delete();
        pc_in = 32'h0000_2000; ce_in = 1'b1;
        tick();
        ce_in = 1'b0;
        tick();
        tick();
        flush = 1'b1; ce_in = 1'b1; pc_in = 32'h0000_3000;
        tick();
        flush = 1'b0;
        total++;
        if (if_valid !== 1'b0 || stall_req !== 1'b0 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle: valid=%b stall=%b req=%b want 0/0/0", if_valid, stall_req, mem_req);
        end
        total++;
        if (issued_q.size() != 2) begin
            bad++;
            $display("FAIL flush_aborted: issued=%0d want 2", issued_q.size());
        end
        issued_q.delete();
        tick();
        ce_in = 1'b0;
        for (int c = 5; c <= 12; c++) begin
            if (if_valid === 1'b1) begin
                nvalid++;
                total++;
                if (c != 10 || if_pc !== 32'h0000_3000 || if_inst !== 32'h0050_0093) begin
                    bad++;
                    $display("FAIL flush_result c=%0d: pc=%h inst=%h want c=10 00003000/00500093",
                             c, if_pc, if_inst);
                end
            end
            tick();
        end
        total++;
        if (nvalid != 1 || issued_q.size() != 4) begin
            bad++;
            $display("FAIL flush_count: pulses=%0d issued=%0d want 1/4", nvalid, issued_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (issued_q[i] !== 32'h0000_3000 + i) begin
                    bad++;
                    $display("FAIL flush_order i=%0d: addr=%h want %h",
                             i, issued_q[i], 32'h0000_3000 + i);
                end
            end
        end
    endtask

    task automatic test_wrap();
        InstructionAddressBus exp_addr[4];
        exp_addr[0] = 32'hFFFF_FFFE; exp_addr[1] = 32'hFFFF_FFFF;
        exp_addr[2] = 32'h0000_0000; exp_addr[3] = 32'h0000_0001;
        pc_in = 32'hFFFF_FFFE; ce_in = 1'b1;
        tick();
        ce_in = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c <= 4) begin
                total++;
                if (mem_req !== 1'b1 || mem_addr !== exp_addr[c-1]) begin
                    bad++;
                    $display("FAIL wrap_addr c=%0d: req=%b addr=%h want 1/%h",
                             c, mem_req, mem_addr, exp_addr[c-1]);
                end
            end
            tick();
        end
        total++;
        if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFE || if_inst !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL wrap_result: valid=%b pc=%h inst=%h want 1/fffffffe/deadbeef",
                     if_valid, if_pc, if_inst);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        pc_in = 32'h0000_1000; ce_in = 1'b1;
        tick();
        pc_in = 32'h0000_3000;
        for (int c = 1; c <= 12; c++) begin
            if (c == 7) ce_in = 1'b0;
            total++;
            if (if_valid !== (c == 6 || c == 12)) begin
                bad++;
                $display("FAIL b2b_valid c=%0d: valid=%b want %b", c, if_valid, (c == 6 || c == 12));
            end else if (c == 6 && (if_pc !== 32'h0000_1000 || if_inst !== 32'h0010_0513)) begin
                bad++;
                $display("FAIL b2b_first: pc=%h inst=%h want 00001000/00100513", if_pc, if_inst);
            end else if (c == 12 && (if_pc !== 32'h0000_3000 || if_inst !== 32'h0050_0093)) begin
                bad++;
                $display("FAIL b2b_second: pc=%h inst=%h want 00003000/00500093", if_pc, if_inst);
            end
            if (c < 12) tick();
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_hold();
        test_flush();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Consumes `pc` and `ce` and reads one 32-bit instruction as four little-endian byte reads from the shared byte-wide memory port.
- Presents `{pc, inst}` to the IF/ID boundary with a valid/stall handshake.
- Drives `stall_req` back so the PC register holds while a fetch is in progress.

Parameters:
ADDR_WIDTH, 32, instruction address width
INST_WIDTH, 32, instruction width; fixed at 4 bytes
MEM_LATENCY, 1, cycles from a granted read to its byte on `mem_din`; only 1 is supported

Ports:
clock  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-low; state resets when reset==0 at posedge
pc_in  in  ADDR_WIDTH  fetch address from the PC register
ce_in  in  1  PC valid / fetch enable
flush  in  1  branch/jump redirect; abort the current fetch
id_stall  in  1  ID stage cannot accept an instruction this cycle
mem_grant  in  1  arbiter accepted `mem_addr` this cycle
mem_din  in  8  read byte, valid MEM_LATENCY cycles after the grant
mem_req  out  1  read request
mem_addr  out  ADDR_WIDTH  byte address
stall_req  out  1  PC register must hold
if_valid  out  1  `if_pc`/`if_inst` valid
if_pc  out  ADDR_WIDTH  address of the presented instruction
if_inst  out  INST_WIDTH  assembled instruction

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; issue_cnt=0; recv_cnt=0; pending=0.
  - All outputs 0: mem_req, mem_addr, stall_req, if_valid, if_pc, if_inst.
  - Reset mid-fetch discards everything; a byte returning the following cycle is ignored.
- States: IDLE, FETCH, HOLD.
- IDLE:
  - stall_req=0, mem_req=0.
  - If ce_in=1 and flush=0: latch pc_in into fetch_pc, clear counters, go to FETCH.
  - If ce_in=0: stay in IDLE.
- FETCH:
  - stall_req=1.
  - While issue_cnt<4: mem_req=1 and mem_addr=fetch_pc+issue_cnt, with ADDR_WIDTH wrap-around.
  - On mem_grant: issue_cnt++ and set pending for the next cycle.
  - When pending: capture mem_din into byte lane recv_cnt (byte0 → inst[7:0], …, byte3 → inst[31:24]), then recv_cnt++.
  - A new issue and a receipt may occur in the same cycle, so back-to-back grants are fully pipelined.
  - mem_grant=0 inserts bubbles; no byte is lost or duplicated.
- Completion (capture of byte3):
  - If id_stall=0: at that posedge set if_valid=1, if_pc=fetch_pc, if_inst=assembled word; go to IDLE.
  - If id_stall=1: go to HOLD with the word retained.
- HOLD:
  - stall_req=1, mem_req=0.
  - When id_stall=0: load the outputs as above and go to IDLE.
- if_valid is a single-cycle pulse per instruction.
  - If id_stall is high in the cycle if_valid is high, the outputs are held (if_valid stays 1) until id_stall=0.
- Latency: pc accepted at edge E0 with mem_grant continuously high gives issues in cycles 1–4, bytes in cycles 2–5, and if_valid high in cycle 6.
  - Steady-state throughput is one instruction per 6 cycles.
- flush=1 at any posedge has priority over everything:
  - go to IDLE, clear counters, force if_valid=0.
  - The outstanding pending byte is dropped: the pending flag is cleared and the next mem_din is not captured.
  - A flush in IDLE only clears if_valid; ce_in is not sampled in that cycle.
- No alignment check; an odd pc fetches 4 consecutive bytes.
- flush and id_stall simultaneous: flush wins.

Decomposition:
- Shared `define.v` gains:
  - InstructionAddressBus (width alias; `pc_in` and `if_pc` use it).
  - InstructionBus [31:0].
  - ByteBus [7:0].
  - Fetch state encodings: FETCH_IDLE=2'd0, FETCH_BUSY=2'd1, FETCH_HOLD=2'd2.
- One natural sub-module: `if_byte_assembler`, which holds the 4-lane byte shift/lane-write register with recv_cnt.
  - The FSM and address generation stay in `if_fetch`.

Test Plan:
- Reset low for 2 cycles mid-FETCH, then high: all outputs 0, state IDLE; the stale mem_din=8'hAA that follows is not captured.
- pc_in=0x00001000, ce_in=1, mem_grant=1, memory returns 13,05,10,00 → mem_addr 1000..1003 in cycles 1–4; if_valid=1 in cycle 6 with if_pc=0x1000, if_inst=0x00100513; stall_req=1 in cycles 1–5.
- Same fetch with mem_grant low in cycles 2 and 3 → addresses still issued in order 1000..1003 exactly once; if_valid in cycle 8 with identical inst.
- id_stall=1 from cycle 4 to 9 → state HOLD, if_valid=0 until id_stall falls; then one valid pulse with the correct inst; no extra mem_req in HOLD.
- flush=1 in cycle 3 of a fetch at 0x2000, then ce_in=1 with pc_in=0x3000 → no if_valid for 0x2000; the next fetch issues 3000..3003 and returns its own bytes only.
- pc_in=0xFFFFFFFE → mem_addr FFFFFFFE, FFFFFFFF, 00000000, 00000001 (wrap); if_pc=0xFFFFFFFE.
